// File: rtl/code_lock_fsm_if.sv
// Keypad / status-LED bundle for code_lock_fsm.
// The master drives the switches and buttons. The slave is the lock controller, which drives the status outputs.
interface code_lock_fsm_if #(
  parameter int CODE_W    = 7,
  parameter int MAX_TRIES = 3
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic [CODE_W-1:0] code_in;
  logic              enter_btn;
  logic              set_btn;
  logic              cancel_btn;
  logic              is_open;
  logic              alarm;
  logic              blink;
  logic [2:0]        state_o;
  logic [TW-1:0]     tries_left;

  modport master (
    output code_in, enter_btn, set_btn, cancel_btn,
    input  is_open, alarm, blink, state_o, tries_left
  );

  modport slave (
    input  code_in, enter_btn, set_btn, cancel_btn,
    output is_open, alarm, blink, state_o, tries_left
  );
endinterface

// File: rtl/code_lock_fsm.sv
// Keypad code-lock controller. It stores a code and opens when the entered code matches.
// It counts wrong attempts and raises a timed, blinking alarm after MAX_TRIES misses.
// Optional feature: define AUTO_RELOCK_EN to relock automatically after OPEN_CYCLES idle cycles in OPENED.
module code_lock_fsm #(
  parameter int                CODE_W       = 7,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 7'h2A,
  parameter int                MAX_TRIES    = 3,
  parameter int                ALARM_CYCLES = 1000,
  parameter int                OPEN_CYCLES  = 500,
  parameter int                BLINK_HALF   = 100
) (
  input logic            clk,
  input logic            rst_n,
  code_lock_fsm_if.slave bus
);
  localparam int TW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (ALARM_CYCLES > OPEN_CYCLES) ? ALARM_CYCLES : OPEN_CYCLES;
  localparam int TMW  = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    SET_AWAIT = 3'b001,
    OPENED    = 3'b010,
    ALARM     = 3'b011
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic [TMW-1:0]    timer_q, timer_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              blink_q, blink_d;
  logic              is_open_q, alarm_q;
  logic [2:0]        btn_q;
  logic              enter_p, set_p, cancel_p;

  // Detect rising edges. A press acts on the same edge where it is first sampled.
  always_comb begin
    enter_p  = bus.enter_btn  & ~btn_q[0];
    set_p    = bus.set_btn    & ~btn_q[1];
    cancel_p = bus.cancel_btn & ~btn_q[2];
  end

  // Compute next state, stored code, attempt counter, timers and blink.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tries_d = tries_q;
    timer_d = timer_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    case (state_q)
      IDLE: begin
        if (enter_p) begin
          if (bus.code_in == code_q) begin
            state_d = OPENED;
            tries_d = TW'(MAX_TRIES);
          end else if (tries_q <= TW'(1)) begin
            state_d = ALARM;
            tries_d = '0;
            blink_d = 1'b1;
            bcnt_d  = '0;
          end else begin
            tries_d = tries_q - TW'(1);
          end
        end
      end
      OPENED: begin
        if (cancel_p) begin
          state_d = IDLE;
        end else if (set_p) begin
          state_d = SET_AWAIT;
`ifdef AUTO_RELOCK_EN
        end else if (enter_p) begin
          timer_d = '0;
        end else if (timer_q == TMW'(OPEN_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMW'(1);
`endif
        end
      end
      SET_AWAIT: begin
        if (cancel_p) begin
          state_d = OPENED;
        end else if (enter_p) begin
          code_d  = bus.code_in;
          state_d = IDLE;
          tries_d = TW'(MAX_TRIES);
        end
      end
      ALARM: begin
        if (timer_q == TMW'(ALARM_CYCLES - 1)) begin
          state_d = IDLE;
          tries_d = TW'(MAX_TRIES);
          blink_d = 1'b0;
        end else begin
          timer_d = timer_q + TMW'(1);
          // The blink counter restarts with the timer on alarm entry.
          // Its wrap therefore matches (timer+1) % BLINK_HALF == 0 without needing a divider.
          if (bcnt_q == BW'(BLINK_HALF - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Update all state and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= DEFAULT_CODE;
      tries_q   <= TW'(MAX_TRIES);
      timer_q   <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      is_open_q <= 1'b0;
      alarm_q   <= 1'b0;
      btn_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      is_open_q <= (state_d == OPENED);
      alarm_q   <= (state_d == ALARM);
      btn_q     <= {bus.cancel_btn, bus.set_btn, bus.enter_btn};
    end
  end

  assign bus.is_open    = is_open_q;
  assign bus.alarm      = alarm_q;
  assign bus.blink      = blink_q;
  assign bus.state_o    = state_q;
  assign bus.tries_left = tries_q;
endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm using short alarm, open and blink timings.
module tb_code_lock_fsm;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  code_lock_fsm_if #(.CODE_W(7), .MAX_TRIES(3)) bus ();

  code_lock_fsm #(
    .CODE_W(7), .DEFAULT_CODE(7'h2A), .MAX_TRIES(3),
    .ALARM_CYCLES(20), .OPEN_CYCLES(10), .BLINK_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic release_all();
    bus.enter_btn  = 1'b0;
    bus.set_btn    = 1'b0;
    bus.cancel_btn = 1'b0;
    tick();
  endtask

  task automatic press_enter(input logic [6:0] c);
    bus.code_in   = c;
    bus.enter_btn = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.code_in = '0;
    bus.enter_btn = 1'b0;
    bus.set_btn = 1'b0;
    bus.cancel_btn = 1'b0;
    tick();
    tick();
    check("rst_state", bus.state_o, 3'b000);
    check("rst_tries", bus.tries_left, 2'd3);
    check("rst_open", bus.is_open, 1'b0);
    check("rst_alarm", bus.alarm, 1'b0);
    check("rst_blink", bus.blink, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: the correct default code opens on the same edge.
    press_enter(7'h2A);
    check("t1_open", bus.is_open, 1'b1);
    check("t1_state", bus.state_o, 3'b010);
    check("t1_tries", bus.tries_left, 2'd3);
    release_all();
    bus.cancel_btn = 1'b1;
    tick();
    check("t1_cancel_state", bus.state_o, 3'b000);
    check("t1_cancel_open", bus.is_open, 1'b0);
    release_all();

    // 2: three misses lead to the alarm, which blinks and then times out.
    press_enter(7'h11);
    check("t2_tries2", bus.tries_left, 2'd2);
    release_all();
    press_enter(7'h11);
    check("t2_tries1", bus.tries_left, 2'd1);
    check("t2_idle", bus.state_o, 3'b000);
    release_all();
    press_enter(7'h11);
    check("t2_alarm", bus.alarm, 1'b1);
    check("t2_state", bus.state_o, 3'b011);
    check("t2_blink0", bus.blink, 1'b1);
    check("t2_tries0", bus.tries_left, 2'd0);
    bus.enter_btn = 1'b0;
    bus.code_in = 7'h2A;
    for (int k = 1; k <= 19; k++) begin
      bus.enter_btn = (k == 6);
      tick();
      check($sformatf("t2_blink_k%0d", k), bus.blink, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("t2_alarm_k%0d", k), bus.state_o, 3'b011);
    end
    bus.enter_btn = 1'b0;
    tick();
    check("t2_end_state", bus.state_o, 3'b000);
    check("t2_end_tries", bus.tries_left, 2'd3);
    check("t2_end_blink", bus.blink, 1'b0);
    check("t2_end_alarm", bus.alarm, 1'b0);

    // 3: change the code to 7'h05.
    press_enter(7'h2A);
    check("t3_open", bus.state_o, 3'b010);
    release_all();
    bus.set_btn = 1'b1;
    tick();
    check("t3_set", bus.state_o, 3'b001);
    check("t3_set_open", bus.is_open, 1'b0);
    release_all();
    press_enter(7'h05);
    check("t3_stored", bus.state_o, 3'b000);
    check("t3_stored_tries", bus.tries_left, 2'd3);
    release_all();
    press_enter(7'h2A);
    check("t3_old_fails", bus.tries_left, 2'd2);
    check("t3_old_state", bus.state_o, 3'b000);
    release_all();
    press_enter(7'h05);
    check("t3_new_opens", bus.state_o, 3'b010);
    check("t3_new_tries", bus.tries_left, 2'd3);
    release_all();
`ifdef AUTO_RELOCK_EN
    tick();
    tick();
    tick();
    press_enter(7'h05);
    check("t6_restart_state", bus.state_o, 3'b010);
    release_all();
    for (int k = 7; k <= 14; k++) tick();
    check("t6_still_open", bus.state_o, 3'b010);
    tick();
    check("t6_relock", bus.state_o, 3'b000);
`else
    for (int k = 0; k < 30; k++) tick();
    check("t3_hold_open", bus.state_o, 3'b010);
    bus.cancel_btn = 1'b1;
    tick();
    check("t3_hold_cancel", bus.state_o, 3'b000);
    release_all();
`endif

    // 4: cancel out of set mode, then set+cancel in the same cycle.
    press_enter(7'h05);
    check("t4_open", bus.state_o, 3'b010);
    release_all();
    bus.set_btn = 1'b1;
    tick();
    check("t4_set", bus.state_o, 3'b001);
    release_all();
    bus.cancel_btn = 1'b1;
    tick();
    check("t4_back_open", bus.state_o, 3'b010);
    check("t4_back_is_open", bus.is_open, 1'b1);
    release_all();
    bus.set_btn = 1'b1;
    bus.cancel_btn = 1'b1;
    tick();
    check("t4_cancel_wins", bus.state_o, 3'b000);
    release_all();
    press_enter(7'h05);
    check("t4_code_kept", bus.state_o, 3'b010);
    release_all();
    bus.cancel_btn = 1'b1;
    tick();
    release_all();

    // 5: a held enter counts once, and reset during the alarm restores the default code.
    bus.code_in = 7'h11;
    bus.enter_btn = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("t5_hold_tries", bus.tries_left, 2'd2);
    release_all();
    press_enter(7'h11);
    release_all();
    press_enter(7'h11);
    check("t5_alarm", bus.state_o, 3'b011);
    release_all();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_state", bus.state_o, 3'b000);
    check("t5_rst_alarm", bus.alarm, 1'b0);
    check("t5_rst_tries", bus.tries_left, 2'd3);
    check("t5_rst_blink", bus.blink, 1'b0);
    rst_n = 1'b1;
    tick();
    press_enter(7'h2A);
    check("t5_default_code", bus.state_o, 3'b010);
    release_all();
    bus.cancel_btn = 1'b1;
    tick();
    release_all();

    // In IDLE, set and cancel are ignored, so enter acts even when they are pressed with it.
    bus.code_in = 7'h2A;
    bus.cancel_btn = 1'b1;
    bus.set_btn = 1'b1;
    bus.enter_btn = 1'b1;
    tick();
    check("idle_enter_acts", bus.state_o, 3'b010);
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
